// File: rtl/ffnn_inference_sequencer_pkg.sv
// ffnn_pkg: shared constants, FSM state encoding and weight-memory address
// helpers for the 4-input feed-forward inference sequencer.
//   N_IN       - number of input features
//   N_OUT      - number of output neurons
//   BIAS_SHIFT - left shift that aligns a bias with the product terms
//   state_t    - sequencer states
//   hid_base() - first weight address of hidden neuron h
//   out_base() - first weight address of output neuron o
package ffnn_pkg;

    localparam int N_IN       = 4;
    localparam int N_OUT      = 2;
    localparam int BIAS_SHIFT = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HID     = 3'd1,
        S_HID_FIN = 3'd2,
        S_OUT     = 3'd3,
        S_OUT_FIN = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    // Each hidden neuron owns N_IN weights followed by one bias.
    function automatic int hid_base(input int h);
        return h * (N_IN + 1);
    endfunction

    // Output neurons follow the hidden block; each owns n_hid weights plus a bias.
    function automatic int out_base(input int n_hid, input int o);
        return (N_IN + 1) * n_hid + o * (n_hid + 1);
    endfunction

endpackage

// File: rtl/ffnn_inference_sequencer_mac.sv
// ffnn_mac: signed multiply-accumulate shared by every neuron.
//   clk, rst  - clock, synchronous active-high reset
//   clr       - clear the accumulator at the next edge (wins over en)
//   en        - add the current term at the next edge
//   bias_sel  - term is the sign-extended, aligned bias instead of a product
//   operand   - unsigned 8-bit activation (input feature or hidden value)
//   w_data    - signed 8-bit weight or bias from the weight memory
//   acc_sum   - running total including this cycle's term; the register
//               loads this value, and neuron activations read it directly so
//               the last term is not lost when the accumulator is cleared
module ffnn_mac
    import ffnn_pkg::*;
#(
    parameter int ACC_W = 20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    bias_sel,
    input  logic [7:0]              operand,
    input  logic signed [7:0]       w_data,
    output logic signed [ACC_W-1:0] acc_sum
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [8:0]       op_s;
    logic signed [16:0]      prod;
    logic signed [ACC_W-1:0] bias_ext;
    logic signed [ACC_W-1:0] term;

    // Activations are unsigned; a zero top bit keeps them positive in the signed product.
    assign op_s     = $signed({1'b0, operand});
    assign prod     = 17'(op_s) * 17'(w_data);
    assign bias_ext = ACC_W'(w_data);
    assign term     = bias_sel ? (bias_ext <<< BIAS_SHIFT) : ACC_W'(prod);
    assign acc_sum  = en ? (acc_q + term) : acc_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_sum;
        end
    end

endmodule

// File: rtl/ffnn_inference_sequencer.sv
// ffnn_inference_sequencer: runs one inference of a 4-input, N_HID-hidden,
// 2-output feed-forward network through a single shared MAC.
//   CLK, RST           - clock, synchronous active-high reset
//   x0..x3, in_valid   - input features, latched when in_valid && in_ready
//   in_ready           - high only while idle
//   w_en, w_addr       - weight-memory read port (addresses strictly ascending)
//   w_data             - signed weight, valid the cycle after w_en
//   y0, y1, out_valid  - binary results, held until out_ready
//   out_ready          - consumer accepts the result
//   busy               - high whenever not idle
//
// state     | meaning
// S_IDLE    | waiting for an input vector
// S_HID     | issuing hidden-neuron weight/bias addresses
// S_HID_FIN | last hidden term lands, activation written to h[n]
// S_OUT     | issuing output-neuron weight/bias addresses
// S_OUT_FIN | last output term lands, y[o] registered
// S_DONE    | result presented until out_ready
module ffnn_inference_sequencer
    import ffnn_pkg::*;
#(
    parameter int N_HID    = 4,
    parameter int SHIFT    = 8,
    parameter int ACC_W    = 20,
    parameter int W_ADDR_W = 5
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [7:0]          x0,
    input  logic [7:0]          x1,
    input  logic [7:0]          x2,
    input  logic [7:0]          x3,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                w_en,
    output logic [W_ADDR_W-1:0] w_addr,
    input  logic signed [7:0]   w_data,
    output logic                y0,
    output logic                y1,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    localparam int CNT_W = 4;

    state_t                  state, state_nxt;
    logic [CNT_W-1:0]        n_cnt;
    logic [CNT_W-1:0]        k_cnt;
    logic [CNT_W-1:0]        idx_d;
    logic                    en_d;
    logic [7:0]              x_r [N_IN];
    logic [7:0]              h_r [N_HID];
    logic                    mac_clr;
    logic                    mac_bias;
    logic [7:0]              mac_op;
    logic signed [ACC_W-1:0] acc_sum;
    logic                    accept;
    logic                    hid_last_term;
    logic                    out_last_term;
    logic                    hid_last_neuron;
    logic                    out_last_neuron;
    logic                    y_pos;

    function automatic logic [7:0] hid_act(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if (a[ACC_W-1]) begin
            return 8'd0;
        end else if (|s[ACC_W-1:8]) begin
            return 8'hFF;
        end else begin
            return s[7:0];
        end
    endfunction

    assign accept          = (state == S_IDLE) && in_valid;
    assign hid_last_term   = (k_cnt == CNT_W'(N_IN));
    assign out_last_term   = (k_cnt == CNT_W'(N_HID));
    assign hid_last_neuron = (n_cnt == CNT_W'(N_HID - 1));
    assign out_last_neuron = (n_cnt == CNT_W'(N_OUT - 1));
    assign y_pos           = !acc_sum[ACC_W-1] && (|acc_sum);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (accept) state_nxt = S_HID;
            S_HID:     if (hid_last_term) state_nxt = S_HID_FIN;
            S_HID_FIN: state_nxt = hid_last_neuron ? S_OUT : S_HID;
            S_OUT:     if (out_last_term) state_nxt = S_OUT_FIN;
            S_OUT_FIN: state_nxt = out_last_neuron ? S_DONE : S_OUT;
            S_DONE:    if (out_ready) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b1;
        w_en      = 1'b0;
        w_addr    = '0;
        out_valid = 1'b0;
        mac_clr   = 1'b0;
        mac_bias  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_HID: begin
                w_en   = 1'b1;
                w_addr = W_ADDR_W'(hid_base(int'(n_cnt)) + int'(k_cnt));
            end
            S_OUT: begin
                w_en   = 1'b1;
                w_addr = W_ADDR_W'(out_base(N_HID, int'(n_cnt)) + int'(k_cnt));
            end
            S_HID_FIN, S_OUT_FIN: begin
                mac_clr  = 1'b1;
                mac_bias = 1'b1;
            end
            S_DONE: out_valid = 1'b1;
            default: ;
        endcase
    end

    // idx_d is the term index of last cycle's address, i.e. the one whose
    // weight is on w_data now.
    always_comb begin
        mac_op = '0;
        if (state == S_OUT) begin
            for (int j = 0; j < N_HID; j++) begin
                if (idx_d == CNT_W'(j)) mac_op = h_r[j];
            end
        end else begin
            for (int j = 0; j < N_IN; j++) begin
                if (idx_d == CNT_W'(j)) mac_op = x_r[j];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            n_cnt <= '0;
            k_cnt <= '0;
            idx_d <= '0;
            en_d  <= 1'b0;
            y0    <= 1'b0;
            y1    <= 1'b0;
            for (int j = 0; j < N_IN; j++) x_r[j] <= '0;
            for (int j = 0; j < N_HID; j++) h_r[j] <= '0;
        end else begin
            idx_d <= k_cnt;
            en_d  <= w_en;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        x_r[0] <= x0;
                        x_r[1] <= x1;
                        x_r[2] <= x2;
                        x_r[3] <= x3;
                        n_cnt  <= '0;
                        k_cnt  <= '0;
                    end
                end
                S_HID, S_OUT: k_cnt <= k_cnt + CNT_W'(1);
                S_HID_FIN: begin
                    k_cnt <= '0;
                    for (int j = 0; j < N_HID; j++) begin
                        if (n_cnt == CNT_W'(j)) h_r[j] <= hid_act(acc_sum);
                    end
                    n_cnt <= hid_last_neuron ? '0 : n_cnt + CNT_W'(1);
                end
                S_OUT_FIN: begin
                    k_cnt <= '0;
                    if (n_cnt == '0) begin
                        y0 <= y_pos;
                    end else begin
                        y1 <= y_pos;
                    end
                    n_cnt <= n_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    ffnn_mac #(
        .ACC_W(ACC_W)
    ) u_mac (
        .clk     (CLK),
        .rst     (RST),
        .clr     (mac_clr),
        .en      (en_d),
        .bias_sel(mac_bias),
        .operand (mac_op),
        .w_data  (w_data),
        .acc_sum (acc_sum)
    );

endmodule

// File: tb/tb_ffnn_inference_sequencer.sv
// Self-checking bench for ffnn_inference_sequencer: directed table vectors,
// backpressure and mid-run reset sequences, then randomized weights/inputs
// compared against an arithmetic network model.
module tb_ffnn_inference_sequencer;

    localparam int NH  = 4;
    localparam int LAT = 6 * NH + 2 * (NH + 2);
    localparam int NADDR = 7 * NH + 2;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic [7:0]        x0, x1, x2, x3;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              w_en;
    logic [4:0]        w_addr;
    logic signed [7:0] w_data;
    logic              y0, y1;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              busy;

    logic signed [7:0] mem [32];
    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [3:0][7:0]  x;
        logic [31:0][7:0] w;
        logic             y0;
        logic             y1;
    } vec_t;

    vec_t vecs [4];

    ffnn_inference_sequencer dut (
        .CLK      (CLK),
        .RST      (RST),
        .x0       (x0),
        .x1       (x1),
        .x2       (x2),
        .x3       (x3),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .w_en     (w_en),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .y0       (y0),
        .y1       (y1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (w_en) w_data <= mem[w_addr];
    end

    function automatic logic [4:0] haddr(input int h, input int i);
        return 5'(h * 5 + i);
    endfunction

    function automatic logic [4:0] oaddr(input int o, input int j);
        return 5'(5 * NH + o * (NH + 1) + j);
    endfunction

    // Returns {y1, y0} for the network currently held in mem.
    function automatic logic [1:0] model(input logic [3:0][7:0] xv);
        int h [NH];
        int acc;
        logic [1:0] y;
        for (int n = 0; n < NH; n++) begin
            acc = 0;
            for (int i = 0; i < 4; i++) acc += int'(xv[i]) * int'(mem[haddr(n, i)]);
            acc += int'(mem[haddr(n, 4)]) * 256;
            if (acc < 0) h[n] = 0;
            else if (acc / 256 > 255) h[n] = 255;
            else h[n] = acc / 256;
        end
        for (int o = 0; o < 2; o++) begin
            acc = 0;
            for (int j = 0; j < NH; j++) acc += h[j] * int'(mem[oaddr(o, j)]);
            acc += int'(mem[oaddr(o, NH)]) * 256;
            y[o] = (acc > 0);
        end
        return y;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic load(input logic [31:0][7:0] w);
        for (int i = 0; i < 32; i++) mem[i] = w[i];
    endtask

    task automatic infer(input string tag, input logic [3:0][7:0] xv,
                         input logic ey0, input logic ey1, input int hold);
        int cnt;
        int gaps;
        int addrs [$];
        @(negedge CLK);
        check({tag, "_in_ready"}, int'(in_ready), 1);
        x0 = xv[0];
        x1 = xv[1];
        x2 = xv[2];
        x3 = xv[3];
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        {x3, x2, x1, x0} = $urandom;
        for (cnt = 0; cnt < 200; cnt++) begin
            @(negedge CLK);
            if (out_valid) break;
            if (w_en) addrs.push_back(int'(w_addr));
            @(posedge CLK);
        end
        check({tag, "_latency"}, cnt, LAT);
        check({tag, "_addr_count"}, addrs.size(), NADDR);
        gaps = 0;
        foreach (addrs[i]) if (addrs[i] != i) gaps++;
        check({tag, "_addr_order_errs"}, gaps, 0);
        check({tag, "_y0"}, int'(y0), int'(ey0));
        check({tag, "_y1"}, int'(y1), int'(ey1));
        for (int c = 0; c < hold; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge CLK);
            @(negedge CLK);
            check({tag, "_hold_vld_rdy_y0_y1"}, int'({out_valid, in_ready, y0, y1}),
                  int'({1'b1, 1'b0, ey0, ey1}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        out_ready = 1'b0;
        check({tag, "_post_out_valid"}, int'(out_valid), 0);
        check({tag, "_post_in_ready"}, int'(in_ready), 1);
        check({tag, "_post_y0_y1"}, int'({y0, y1}), int'({ey0, ey1}));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0][7:0] xv;
        logic [1:0]      ey;
        int              v;
        bit              saw;

        for (int i = 0; i < 4; i++) vecs[i] = '0;
        // all-zero network
        vecs[0].x = {8'd76, 8'd81, 8'd205, 8'd158};
        vecs[0].y0 = 1'b0; vecs[0].y1 = 1'b0;
        // diagonal hidden layer, h0 = 158*127>>8 = 78
        vecs[1].x = {8'd30, 8'd20, 8'd10, 8'd158};
        for (int h = 0; h < NH; h++) vecs[1].w[haddr(h, h)] = 8'd127;
        vecs[1].w[oaddr(0, 0)] = 8'd1;
        vecs[1].w[oaddr(1, 0)] = 8'hFF;
        vecs[1].y0 = 1'b1; vecs[1].y1 = 1'b0;
        // saturation: acc=162052 -> h0=255; o0 bias -1 -> -1, o1 bias 0 -> 255
        vecs[2].x = {4{8'd255}};
        for (int i = 0; i < 5; i++) vecs[2].w[haddr(0, i)] = 8'd127;
        vecs[2].w[oaddr(0, 0)]  = 8'd1;
        vecs[2].w[oaddr(0, NH)] = 8'hFF;
        vecs[2].w[oaddr(1, 0)]  = 8'd1;
        vecs[2].y0 = 1'b0; vecs[2].y1 = 1'b1;
        // negative hidden: h0=0, o0 acc=0 -> 0, o1 bias 1 -> 256
        vecs[3].x = {8'd9, 8'd9, 8'd9, 8'd200};
        vecs[3].w[haddr(0, 0)]  = 8'h80;
        vecs[3].w[oaddr(0, 0)]  = 8'd1;
        vecs[3].w[oaddr(1, 0)]  = 8'd1;
        vecs[3].w[oaddr(1, NH)] = 8'd1;
        vecs[3].y0 = 1'b0; vecs[3].y1 = 1'b1;

        x0 = '0; x1 = '0; x2 = '0; x3 = '0;
        load(vecs[0].w);
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_w_en", int'(w_en), 0);
        check("rst_w_addr", int'(w_addr), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_y0_y1", int'({y0, y1}), 0);
        RST = 1'b0;

        for (int i = 0; i < 4; i++) begin
            load(vecs[i].w);
            infer($sformatf("vec%0d", i), vecs[i].x, vecs[i].y0, vecs[i].y1, i);
        end

        load(vecs[1].w);
        infer("backpressure", vecs[1].x, 1'b1, 1'b0, 10);

        // reset pulse partway through a run
        @(negedge CLK);
        x0 = 8'd158; x1 = 8'd10; x2 = 8'd20; x3 = 8'd30;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check("midrst_in_ready", int'(in_ready), 1);
        check("midrst_busy", int'(busy), 0);
        check("midrst_w_en", int'(w_en), 0);
        check("midrst_out_valid", int'(out_valid), 0);
        saw = 1'b0;
        repeat (50) begin
            @(negedge CLK);
            if (out_valid) saw = 1'b1;
        end
        check("midrst_no_out_valid", int'(saw), 0);
        load(vecs[2].w);
        infer("after_rst", vecs[2].x, 1'b0, 1'b1, 0);

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 32; i++) begin
                if (r % 2 == 0) v = int'($urandom_range(0, 255));
                else v = int'($urandom_range(0, 15)) - 8;
                mem[i] = 8'(v);
            end
            xv = $urandom;
            ey = model(xv);
            infer($sformatf("rand%0d", r), xv, ey[0], ey[1], int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
